// File: rtl/vector_fetch.sv
// vector_fetch
//   Fetches a 16-bit interrupt/reset vector from memory as two byte reads
//   (lo at base, hi at base+1) and presents it on pc with a one-cycle
//   pc_valid pulse. Reset performs an automatic boot fetch of FFFC/FFFD.
//
// Parameters
//   MEM_LAT   cycles from the mem_rd strobe cycle to the mem_data sample (1..3)
//
// Ports
//   ph1       clock, rising edge
//   resetb    asynchronous active-low reset
//   req       fetch request, honoured only while idle
//   vsel      vector select: 00 NMI FFFA, 01 RESET FFFC, 10 IRQ/BRK FFFE, 11 RESET FFFC
//   mem_adr   memory read address (0000 when not strobing)
//   mem_rd    one-cycle read strobe
//   mem_data  read data from memory
//   pc        fetched vector
//   pc_valid  one-cycle pulse when pc takes a new vector
//   busy      high whenever a fetch is in progress
//   cpu_hold  stalls the CPU controller while a fetch is in progress
module vector_fetch #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        ph1,
    input  logic        resetb,
    input  logic        req,
    input  logic [1:0]  vsel,
    output logic [15:0] mem_adr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    output logic [15:0] pc,
    output logic        pc_valid,
    output logic        busy,
    output logic        cpu_hold
);

    localparam logic [2:0] LO_REQ  = 3'd0;
    localparam logic [2:0] LO_WAIT = 3'd1;
    localparam logic [2:0] HI_REQ  = 3'd2;
    localparam logic [2:0] HI_WAIT = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;
    localparam logic [2:0] IDLE    = 3'd5;

    // Wait counter preload: counts down to zero on the sampling cycle.
    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

    logic [2:0]  state_q, state_d;
    logic [1:0]  cnt_q,   cnt_d;
    logic [15:0] base_q,  base_d;
    logic [7:0]  lo_q,    lo_d;
    logic [7:0]  hi_q,    hi_d;
    logic [15:0] pc_q,    pc_d;

    function automatic logic [15:0] vec_addr(input logic [1:0] sel);
        case (sel)
            2'b00:   return 16'hFFFA;
            2'b10:   return 16'hFFFE;
            default: return 16'hFFFC;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    base_d  = vec_addr(vsel);
                    state_d = LO_REQ;
                end
            end
            LO_REQ: begin
                cnt_d   = LAT_LAST;
                state_d = LO_WAIT;
            end
            LO_WAIT: begin
                if (cnt_q == 2'd0) begin
                    lo_d    = mem_data;
                    state_d = HI_REQ;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            HI_REQ: begin
                cnt_d   = LAT_LAST;
                state_d = HI_WAIT;
            end
            HI_WAIT: begin
                if (cnt_q == 2'd0) begin
                    hi_d    = mem_data;
                    // Both bytes land in pc on the edge into DONE, so pc
                    // first shows the new vector in the pc_valid cycle and
                    // never exposes a half-updated value.
                    pc_d    = {mem_data, lo_q};
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ph1 or negedge resetb) begin
        if (!resetb) begin
            state_q <= LO_REQ;
            cnt_q   <= '0;
            base_q  <= 16'hFFFC;
            lo_q    <= '0;
            hi_q    <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            pc_q    <= pc_d;
        end
    end

    // The reset state is LO_REQ so the boot read begins as soon as resetb
    // rises; the strobe itself is suppressed while reset is held.
    always_comb begin
        mem_rd  = 1'b0;
        mem_adr = '0;
        if (state_q == LO_REQ) begin
            mem_rd  = resetb;
            mem_adr = base_q;
        end else if (state_q == HI_REQ) begin
            mem_rd  = resetb;
            mem_adr = base_q + 16'd1;
        end
    end

    assign pc       = pc_q;
    assign pc_valid = (state_q == DONE);
    assign cpu_hold = (state_q != IDLE);
    assign busy     = cpu_hold;

endmodule

// File: tb/tb_vector_fetch.sv
module tb_vector_fetch;

    typedef struct {
        logic        req;
        logic [1:0]  vsel;
        logic        rd;
        logic [15:0] adr;
        logic        pcv;
        logic [15:0] pc;
        logic        hold;
    } vec_t;

    logic ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    logic       rstn [2];
    logic       rq   [2];
    logic [1:0] vs   [2];

    logic [15:0] adr0, adr1, pc0, pc1;
    logic        rd0, rd1, pcv0, pcv1, busy0, busy1, hold0, hold1;
    logic [7:0]  md0, md1;

    logic [15:0] adr [2];
    logic [15:0] pcs [2];
    logic        rd  [2];
    logic        pcv [2];
    logic        bsy [2];
    logic        hld [2];

    always_comb begin
        adr[0] = adr0;  adr[1] = adr1;
        pcs[0] = pc0;   pcs[1] = pc1;
        rd[0]  = rd0;   rd[1]  = rd1;
        pcv[0] = pcv0;  pcv[1] = pcv1;
        bsy[0] = busy0; bsy[1] = busy1;
        hld[0] = hold0; hld[1] = hold1;
    end

    vector_fetch #(.MEM_LAT(1)) u_lat1 (
        .ph1(ph1), .resetb(rstn[0]), .req(rq[0]), .vsel(vs[0]),
        .mem_adr(adr0), .mem_rd(rd0), .mem_data(md0),
        .pc(pc0), .pc_valid(pcv0), .busy(busy0), .cpu_hold(hold0)
    );

    vector_fetch #(.MEM_LAT(3)) u_lat3 (
        .ph1(ph1), .resetb(rstn[1]), .req(rq[1]), .vsel(vs[1]),
        .mem_adr(adr1), .mem_rd(rd1), .mem_data(md1),
        .pc(pc1), .pc_valid(pcv1), .busy(busy1), .cpu_hold(hold1)
    );

    // Vector ROM bytes FFFA..FFFF, byte 0 (FFFA) in the low bits.
    logic [47:0] vrom = 48'hABCD_F000_1234;

    function automatic logic [7:0] rom(input logic [47:0] t, input logic [15:0] a);
        int unsigned o;
        if (a >= 16'hFFFA) begin
            o = 32'(a - 16'hFFFA);
            return t[o*8 +: 8];
        end
        return a[7:0] ^ 8'h5A;
    endfunction

    // Memory models: data is valid only in the cycle exactly MEM_LAT cycles
    // after the strobe; any other cycle returns filler.
    logic [16:0] p0;
    logic [16:0] p1 [3];
    always_ff @(posedge ph1) begin
        p0    <= {rd0, adr0};
        p1[0] <= {rd1, adr1};
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end
    always_comb begin
        md0 = p0[16]    ? rom(vrom, p0[15:0])    : 8'hEE;
        md1 = p1[2][16] ? rom(vrom, p1[2][15:0]) : 8'hEE;
    end

    int n_chk  = 0;
    int n_fail = 0;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void add(input logic r, input logic [1:0] v, input logic erd,
                                input logic [15:0] eadr, input logic epcv,
                                input logic [15:0] epc, input logic ehold);
        vec_t e;
        e.req = r; e.vsel = v; e.rd = erd; e.adr = eadr;
        e.pcv = epcv; e.pc = epc; e.hold = ehold;
        tbl.push_back(e);
    endfunction

    // One complete fetch from the strobe cycle (cycle 1) to the first idle
    // cycle: reads at cycles 1 and lat+2, pc_valid at 2*(lat+1)+1.
    function automatic void add_fetch(input int lat, input logic [15:0] base,
                                      input logic [15:0] old_pc, input logic [15:0] new_pc);
        int len = 2 * (lat + 1) + 1;
        for (int c = 1; c <= len; c++) begin
            add(1'b0, 2'b00,
                (c == 1) || (c == lat + 2),
                (c == 1) ? base : (c == lat + 2) ? base + 16'd1 : 16'h0000,
                c == len,
                (c == len) ? new_pc : old_pc,
                1'b1);
        end
        add(1'b0, 2'b00, 1'b0, 16'h0000, 1'b0, new_pc, 1'b0);
    endfunction

    task automatic run_tbl(input int d, input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            chk($sformatf("%s[%0d].rd", tag, i),   16'(rd[d]),  16'(tbl[i].rd));
            chk($sformatf("%s[%0d].adr", tag, i),  adr[d],      tbl[i].adr);
            chk($sformatf("%s[%0d].pcv", tag, i),  16'(pcv[d]), 16'(tbl[i].pcv));
            chk($sformatf("%s[%0d].pc", tag, i),   pcs[d],      tbl[i].pc);
            chk($sformatf("%s[%0d].hold", tag, i), 16'(hld[d]), 16'(tbl[i].hold));
            chk($sformatf("%s[%0d].busy", tag, i), 16'(bsy[d]), 16'(tbl[i].hold));
            rq[d] = tbl[i].req;
            vs[d] = tbl[i].vsel;
            @(posedge ph1);
            @(negedge ph1);
        end
        tbl.delete();
        rq[d] = 1'b0;
    endtask

    task automatic chk_reset(input int d, input string tag);
        chk({tag, ".pc"},   pcs[d],      16'h0000);
        chk({tag, ".rd"},   16'(rd[d]),  16'h0000);
        chk({tag, ".pcv"},  16'(pcv[d]), 16'h0000);
        chk({tag, ".hold"}, 16'(hld[d]), 16'h0001);
        chk({tag, ".busy"}, 16'(bsy[d]), 16'h0001);
    endtask

    function automatic logic [15:0] base_of(input logic [1:0] v);
        case (v)
            2'b00:   return 16'hFFFA;
            2'b10:   return 16'hFFFE;
            default: return 16'hFFFC;
        endcase
    endfunction

    // Random requests and occasional reset pulses against a cycle-position
    // model of the fetch built from the latency rules.
    task automatic rand_run(input int d, input int lat, input int n);
        int          len = 2 * (lat + 1) + 1;
        int          k = 0;
        logic [15:0] mbase = 16'hFFFC;
        logic [15:0] mpc = 16'hF000;
        logic        r, rp;
        logic [1:0]  v;
        vrom = {16'($urandom), 32'($urandom)};
        for (int i = 0; i < n; i++) begin
            chk("rnd.rd",   16'(rd[d]), 16'((k == 1) || (k == lat + 2)));
            chk("rnd.adr",  adr[d], (k == 1) ? mbase : (k == lat + 2) ? mbase + 16'd1 : 16'h0000);
            chk("rnd.pcv",  16'(pcv[d]), 16'(k == len));
            chk("rnd.pc",   pcs[d], mpc);
            chk("rnd.hold", 16'(hld[d]), 16'(k != 0));
            r  = ($urandom_range(0, 3) == 0);
            v  = 2'($urandom_range(0, 3));
            rp = ($urandom_range(0, 59) == 0);
            rq[d] = r;
            vs[d] = v;
            if (rp) begin
                rstn[d] = 1'b0;
                #1;
                chk_reset(d, "rnd.rst");
                #1;
                rstn[d] = 1'b1;
            end
            @(posedge ph1);
            if (rp) begin
                mbase = 16'hFFFC;
                mpc   = 16'h0000;
                k     = 2;
            end else if (k == 0) begin
                if (r) begin
                    mbase = base_of(v);
                    k     = 1;
                end
            end else if (k == len) begin
                k = 0;
            end else begin
                k++;
                if (k == len) mpc = {rom(vrom, mbase + 16'd1), rom(vrom, mbase)};
            end
            @(negedge ph1);
        end
        rq[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rstn[d] = 1'b0;
            rq[d]   = 1'b0;
            vs[d]   = 2'b00;
        end
        repeat (3) @(posedge ph1);
        @(negedge ph1);
        chk_reset(0, "rst0");
        chk_reset(1, "rst1");

        // Boot, MEM_LAT=1
        rstn[0] = 1'b1;
        #1;
        add_fetch(1, 16'hFFFC, 16'h0000, 16'hF000);
        run_tbl(0, "boot1");

        // NMI, with an IRQ request arriving in HI_WAIT and DONE that must be dropped
        add(1'b1, 2'b00, 1'b0, 16'h0000, 1'b0, 16'hF000, 1'b0);
        add(1'b0, 2'b00, 1'b1, 16'hFFFA, 1'b0, 16'hF000, 1'b1);
        add(1'b0, 2'b00, 1'b0, 16'h0000, 1'b0, 16'hF000, 1'b1);
        add(1'b0, 2'b00, 1'b1, 16'hFFFB, 1'b0, 16'hF000, 1'b1);
        add(1'b1, 2'b10, 1'b0, 16'h0000, 1'b0, 16'hF000, 1'b1);
        add(1'b1, 2'b10, 1'b0, 16'h0000, 1'b1, 16'h1234, 1'b1);
        add(1'b0, 2'b00, 1'b0, 16'h0000, 1'b0, 16'h1234, 1'b0);
        add(1'b0, 2'b00, 1'b0, 16'h0000, 1'b0, 16'h1234, 1'b0);
        add(1'b0, 2'b00, 1'b0, 16'h0000, 1'b0, 16'h1234, 1'b0);
        run_tbl(0, "nmi");

        // IRQ aborted by reset in HI_WAIT
        add(1'b1, 2'b10, 1'b0, 16'h0000, 1'b0, 16'h1234, 1'b0);
        add(1'b0, 2'b00, 1'b1, 16'hFFFE, 1'b0, 16'h1234, 1'b1);
        add(1'b0, 2'b00, 1'b0, 16'h0000, 1'b0, 16'h1234, 1'b1);
        add(1'b0, 2'b00, 1'b1, 16'hFFFF, 1'b0, 16'h1234, 1'b1);
        run_tbl(0, "irq");
        chk("irq.hiwait.hold", 16'(hld[0]), 16'h0001);
        rstn[0] = 1'b0;
        #1;
        chk_reset(0, "abort.a");
        @(posedge ph1);
        @(negedge ph1);
        chk_reset(0, "abort.b");
        rstn[0] = 1'b1;
        #1;
        add_fetch(1, 16'hFFFC, 16'h0000, 16'hF000);
        run_tbl(0, "reboot");

        // MEM_LAT=3: boot, then requested RESET vector via vsel=11
        rstn[1] = 1'b1;
        #1;
        add_fetch(3, 16'hFFFC, 16'h0000, 16'hF000);
        run_tbl(1, "boot3");
        add(1'b1, 2'b11, 1'b0, 16'h0000, 1'b0, 16'hF000, 1'b0);
        add_fetch(3, 16'hFFFC, 16'hF000, 16'hF000);
        run_tbl(1, "v11");

        rand_run(0, 1, 600);
        rand_run(1, 3, 600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_fetch.md
VECTOR_FETCH -- requirements
Module: vector_fetch

Interface
REQ-001 The block SHALL have parameter MEM_LAT, default 1, which sets the cycles from the mem_rd strobe cycle to the cycle mem_data is sampled; legal values are 1..3.
REQ-002 The block SHALL have port ph1, input, 1 bit: the single clock; all flops trigger on its rising edge.
REQ-003 The block SHALL have port resetb, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req, input, 1 bit: vector fetch request, sampled each cycle.
REQ-005 The block SHALL have port vsel, input, 2 bits: vector select; 00 = NMI (FFFA), 01 = RESET (FFFC), 10 = IRQ/BRK (FFFE), 11 = RESET (FFFC).
REQ-006 The block SHALL have port mem_adr, output, 16 bits: memory read address.
REQ-007 The block SHALL have port mem_rd, output, 1 bit: one-cycle read strobe.
REQ-008 The block SHALL have port mem_data, input, 8 bits: read data from the ROM/RAM array.
REQ-009 The block SHALL have port pc, output, 16 bits: fetched vector, to the datapath PC latches.
REQ-010 The block SHALL have port pc_valid, output, 1 bit: one-cycle pulse when pc is updated.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-012 The block SHALL have port cpu_hold, output, 1 bit: stalls the CPU controller while a fetch is in progress.

Function
REQ-013 The FSM SHALL have states LO_REQ, LO_WAIT, HI_REQ, HI_WAIT, DONE and IDLE.
REQ-014 In LO_REQ, mem_rd SHALL be 1 and mem_adr SHALL be the base vector address; the next state SHALL be LO_WAIT.
REQ-015 LO_WAIT SHALL last MEM_LAT cycles (internal counter); mem_data SHALL be captured into an internal lo register on the last of those cycles; the next state SHALL be HI_REQ.
REQ-016 In HI_REQ, mem_rd SHALL be 1 and mem_adr SHALL be base+1; the next state SHALL be HI_WAIT.
REQ-017 HI_WAIT SHALL mirror LO_WAIT, capturing into an internal hi register; the next state SHALL be DONE.
REQ-018 In DONE, pc SHALL load {hi,lo} atomically and pc_valid SHALL be 1 for exactly that cycle; the next state SHALL be IDLE unconditionally.
REQ-019 pc SHALL change only on DONE; intermediate bytes SHALL never appear on pc.
REQ-020 Outside LO_REQ and HI_REQ, mem_rd SHALL be 0 and mem_adr SHALL be 16'h0000.
REQ-021 In IDLE, req=1 SHALL latch vsel into the internal base register and move to LO_REQ on the next cycle.
REQ-022 req in any non-IDLE state, including DONE, SHALL be ignored with no queuing, and vsel changes during a fetch SHALL have no effect.
REQ-023 cpu_hold SHALL be 1 in every state except IDLE; it SHALL fall on the first IDLE cycle.
REQ-024 busy SHALL equal cpu_hold.
REQ-025 Fetch latency SHALL be: pc_valid in cycle 2*(MEM_LAT+1)+1 counted from the LO_REQ cycle as cycle 1 (5 cycles for MEM_LAT=1).
REQ-026 Base addresses SHALL be FFFA/FFFC/FFFE with the hi byte at base+1, so no address wrap occurs.

Reset
REQ-027 While resetb=0: state SHALL be LO_REQ, base SHALL be FFFC, pc SHALL be 16'h0000, lo/hi SHALL be 00, pc_valid SHALL be 0, cpu_hold SHALL be 1, busy SHALL be 1.
REQ-028 While resetb=0, mem_rd SHALL be forced to 0.
REQ-029 The first rising edge of ph1 with resetb=1 SHALL begin the boot fetch of the RESET vector without req.
REQ-030 Reset asserted mid-fetch SHALL abort immediately (asynchronously); partial bytes SHALL be discarded and the boot fetch SHALL restart after release.

Verification
REQ-031 The bench SHALL cover boot with MEM_LAT=1, ROM FFFC=00, FFFD=F0, and verify: mem_rd at cycles 1 and 3 with addresses FFFC/FFFD; pc=F000 and pc_valid=1 at cycle 5; cpu_hold=0 at cycle 6.
REQ-032 The bench SHALL cover NMI: with FFFA=34, FFFB=12, req=1 and vsel=00 in IDLE, and verify pc=1234 with pc_valid 5 cycles after LO_REQ, pc held at F000 until then.
REQ-033 The bench SHALL cover req=1 with vsel=10 asserted during the HI_WAIT of an ongoing NMI fetch, and verify it is ignored: pc=1234, then IDLE, and no further mem_rd.
REQ-034 The bench SHALL cover resetb pulsed low during HI_WAIT of an IRQ fetch (FFFE=CD, FFFF=AB), and verify: pc=0000 and mem_rd=0 during reset, then boot refetch yields pc=F000, never ABCD.
REQ-035 The bench SHALL cover MEM_LAT=3 with vsel=11, and verify: reads at cycles 1 and 5 addressing FFFC/FFFD; pc_valid at cycle 9 with pc=F000.
